// File: rtl/posit_accumulator.sv
// posit_accumulator: streaming posit<NBITS,ES> group sum; combinational posit adder feeding a single acc register.
// Define POSIT_ACC_COUNT_EN to add the CNT_W-bit out_count beat counter.
module posit_accumulator #(
  parameter int NBITS = 32,
  parameter int ES = 2
`ifdef POSIT_ACC_COUNT_EN
  ,parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [NBITS-1:0] out_data,
  output logic             out_inf,
  output logic             out_zero,
  output logic             out_valid,
`ifdef POSIT_ACC_COUNT_EN
  output logic [CNT_W-1:0] out_count,
`endif
  input  logic             out_ready
);
  localparam int MW = NBITS - ES;
  localparam int G = 3;
  localparam int SN = MW + G + 1;
  localparam int SCW = $clog2(NBITS) + ES + 3;
  localparam int W = NBITS + 2 + ES + SN - 1;
  localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};
  typedef enum logic {ACCUM, HOLD} state_t;
  typedef struct packed {
    logic                  sgn;
    logic signed [SCW-1:0] sc;
    logic [MW-1:0]         m;
  } unp_t;
  // Unpack a finite nonzero posit into sign, scale and mantissa with hidden bit.
  function automatic unp_t decode(input logic [NBITS-1:0] x);
    logic [NBITS-2:0] rem, t, sh;
    logic signed [SCW-ES-1:0] k;
    int r;
    unp_t u;
    rem = x[NBITS-1] ? -x[NBITS-2:0] : x[NBITS-2:0];
    t = rem[NBITS-2] ? ~rem : rem;
    r = NBITS - 1;
    for (int i = 0; i < NBITS - 1; i++) if (t[i]) r = NBITS - 2 - i;
    k = rem[NBITS-2] ? (SCW-ES)'(r - 1) : -(SCW-ES)'(r);
    sh = rem << (r + 1);
    u.sgn = x[NBITS-1];
    u.sc = {k, sh[NBITS-2 -: ES]};
    u.m = {1'b1, sh[NBITS-2-ES:0]};
    return u;
  endfunction
  state_t state, state_d;
  logic [NBITS-1:0] acc, acc_d, add_res;
  logic acc_inf, acc_zero, inf_d, zero_d, add_zero, accept, clear, nar_in;
  unp_t a, b, l, s;
  logic swap, sticky, g, st;
  logic [SCW-1:0] diff;
  logic [SN-2:0] ext_s, ms, ml, norm;
  logic [SN-1:0] sum;
  logic signed [SCW-1:0] sc, k;
  int lz, kc, amt;
  logic [W-1:0] pat, shd;
  logic [NBITS-2:0] body, rnd, mag;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ACCUM;
    else state <= state_d;
  always_comb
    state_d = (state == ACCUM && accept && in_last) ? HOLD : (state == HOLD && out_ready) ? ACCUM : state;
  always_comb begin
    in_ready = state == ACCUM;
    out_valid = state == HOLD;
  end
  assign accept = in_valid && in_ready;
  assign clear = out_valid && out_ready;
  // Adder: align smaller operand with sticky jammed into LSB, add/sub, normalise, encode with RNE.
  always_comb begin
    a = decode(acc);
    b = decode(in_data);
    swap = ($signed(b.sc) > $signed(a.sc)) || (b.sc == a.sc && b.m > a.m);
    l = swap ? b : a;
    s = swap ? a : b;
    diff = l.sc - s.sc;
    ml = {l.m, {G{1'b0}}};
    ext_s = {s.m, {G{1'b0}}};
    ms = ext_s >> diff;
    sticky = (ms << diff) != ext_s;
    sum = (l.sgn == s.sgn) ? {1'b0, ml} + {1'b0, ms[SN-2:1], ms[0] | sticky}
                           : {1'b0, ml} - {1'b0, ms[SN-2:1], ms[0] | sticky};
    lz = SN;
    for (int i = 0; i < SN; i++) if (sum[i]) lz = SN - 1 - i;
    norm = (SN-1)'(sum << lz);
    sc = $signed(l.sc) + SCW'(1) - SCW'(lz);
    k = sc >>> ES;
    kc = (k > NBITS - 2) ? NBITS - 2 : int'(k);
    amt = kc >= 0 ? kc : -kc - 1;
    pat = {(kc >= 0) ? 2'b10 : 2'b01, sc[ES-1:0], norm, {NBITS{1'b0}}};
    shd = $signed(pat) >>> amt;
    body = shd[W-1 -: NBITS-1];
    g = shd[W-NBITS];
    st = |shd[W-NBITS-1:0];
    rnd = body + (NBITS-1)'(g && (st || body[0]));
    mag = (k < -(NBITS - 2)) ? (NBITS-1)'(1) : rnd;
    add_zero = sum == '0;
    add_res = add_zero ? '0 : (l.sgn ? -{1'b0, mag} : {1'b0, mag});
  end
  always_comb begin
    nar_in = in_data == NAR;
    inf_d = acc_inf || nar_in;
    acc_d = inf_d ? NAR : acc_zero ? in_data : (in_data == '0) ? acc : add_res;
    zero_d = !inf_d && (acc_zero ? in_data == '0 : (in_data != '0) && add_zero);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset || clear) begin
      acc <= '0;
      acc_inf <= 1'b0;
      acc_zero <= 1'b1;
    end else if (accept) begin
      acc <= acc_d;
      acc_inf <= inf_d;
      acc_zero <= zero_d;
    end
  assign out_data = acc;
  assign out_inf = acc_inf;
  assign out_zero = acc_zero;
`ifdef POSIT_ACC_COUNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset || clear) cnt <= '0;
    else if (accept && cnt != '1) cnt <= cnt + CNT_W'(1);
  assign out_count = cnt;
`endif
endmodule
